// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
// Redirect source priority enum plus default vectors and width.
package pc_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] RST_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF = 32'h0000_0080;

  // Numeric order is priority order; the pending latch relies on it.
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_JUMP = 3'd1,
    SRC_BR   = 3'd2,
    SRC_JR   = 3'd3,
    SRC_ERET = 3'd4,
    SRC_EXC  = 3'd5
  } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// Request/status bundle between control logic and pc_gen.
// master: hazard/decode/exception side; slave: pc_gen.
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);

  logic             stall;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             exc;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] epc;
  logic             redirect;
  logic             addr_err;

  modport master (
    output stall, jump, jump_target,
    output branch_taken, branch_target,
    output jr, jr_target,
    output exc, exc_pc, eret,
    input  pc, pc_plus, epc,
    input  redirect, addr_err
  );

  modport slave (
    input  stall, jump, jump_target,
    input  branch_taken, branch_target,
    input  jr, jr_target,
    input  exc, exc_pc, eret,
    output pc, pc_plus, epc,
    output redirect, addr_err
  );

endinterface

// File: rtl/pc_redirect_latch.sv
// Holds a redirect that arrived while fetch was stalled.
// Ports: clk/rst, clr_i, cap_i, src_i/tgt_i in; vld_o, src_o, tgt_o out.
module pc_redirect_latch
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             cap_i,
  input  pc_src_e          src_i,
  input  logic [WIDTH-1:0] tgt_i,
  output logic             vld_o,
  output pc_src_e          src_o,
  output logic [WIDTH-1:0] tgt_o
);

  logic             vld_q, vld_d;
  pc_src_e          src_q, src_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;

  always_comb begin
    vld_d = vld_q;
    src_d = src_q;
    tgt_d = tgt_q;
    if (clr_i) begin
      vld_d = 1'b0;
      src_d = SRC_SEQ;
    end else if (cap_i && (!vld_q || src_i >= src_q)) begin
      // Equal priority overwrites: the newer request wins.
      vld_d = 1'b1;
      src_d = src_i;
      tgt_d = tgt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      src_q <= SRC_SEQ;
      tgt_q <= '0;
    end else begin
      vld_q <= vld_d;
      src_q <= src_d;
      tgt_q <= tgt_d;
    end
  end

  assign vld_o = vld_q;
  assign src_o = src_q;
  assign tgt_o = tgt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register, EPC and next-PC priority select.
// Ports: clk, rst (sync, active-high), bus (pc_gen_if.slave).
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = PC_W,
  parameter int unsigned      INC        = 4,
  parameter logic [WIDTH-1:0] RESET_VEC  = RST_VEC_DEF,
  parameter logic [WIDTH-1:0] EXC_VEC    = EXC_VEC_DEF,
  parameter int unsigned      ALIGN_BITS = 2
) (
  input logic clk,
  input logic rst,
  pc_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] AMASK =
    (ALIGN_BITS == 0) ? '0 :
    WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             redir_q, redir_d;
  logic             aerr_q, aerr_d;

  pc_src_e          req_src;
  logic [WIDTH-1:0] req_tgt;
  logic             req;
  logic             pend_vld;
  pc_src_e          pend_src;
  logic [WIDTH-1:0] pend_tgt;
  logic             pend_clr;
  logic             pend_cap;
  logic [WIDTH-1:0] sel_tgt;
  logic             sel_vld;
  logic             misal;

  always_comb begin
    req_src = SRC_SEQ;
    req_tgt = '0;
    priority case (1'b1)
      bus.jr: begin
        req_src = SRC_JR;
        req_tgt = bus.jr_target;
      end
      bus.branch_taken: begin
        req_src = SRC_BR;
        req_tgt = bus.branch_target;
      end
      bus.jump: begin
        req_src = SRC_JUMP;
        req_tgt = bus.jump_target;
      end
      default: ;
    endcase
  end

  assign req     = (req_src != SRC_SEQ);
  // A fresh redirect on release beats the pending one.
  assign sel_vld = req | pend_vld;
  assign sel_tgt = req ? req_tgt : pend_tgt;
  assign misal   = |(sel_tgt & AMASK);

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    redir_d  = 1'b0;
    aerr_d   = 1'b0;
    pend_clr = 1'b0;
    pend_cap = 1'b0;
    if (bus.exc) begin
      pc_d     = EXC_VEC;
      epc_d    = bus.exc_pc;
      redir_d  = 1'b1;
      pend_clr = 1'b1;
    end else if (bus.eret) begin
      pc_d     = epc_q;
      redir_d  = 1'b1;
      pend_clr = 1'b1;
    end else if (bus.stall) begin
      pend_cap = req;
    end else begin
      pend_clr = 1'b1;
      if (sel_vld) begin
        redir_d = 1'b1;
        if (misal) begin
          // Trap: EPC records the PC that issued the bad target.
          pc_d   = EXC_VEC;
          epc_d  = pc_q;
          aerr_d = 1'b1;
        end else begin
          pc_d = sel_tgt;
        end
      end else begin
        pc_d = pc_q + INC_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      redir_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      redir_q <= redir_d;
      aerr_q  <= aerr_d;
    end
  end

  pc_redirect_latch #(
    .WIDTH (WIDTH)
  ) u_latch (
    .clk   (clk),
    .rst   (rst),
    .clr_i (pend_clr),
    .cap_i (pend_cap),
    .src_i (req_src),
    .tgt_i (req_tgt),
    .vld_o (pend_vld),
    .src_o (pend_src),
    .tgt_o (pend_tgt)
  );

  // Priority is only used inside the latch.
  logic unused_src;
  assign unused_src = ^pend_src;

  assign bus.pc       = pc_q;
  assign bus.pc_plus  = pc_q + INC_W;
  assign bus.epc      = epc_q;
  assign bus.redirect = redir_q;
  assign bus.addr_err = aerr_q;

endmodule
